// File: rtl/sdp_c_core_pipe_ctrl.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : sdp_c_core_pipe_ctrl                                            |
// | Purpose  : SDP C-core sequencer: stage valids, core_wen, IDLE/RUN/DRAIN.   |
// | Option   : SDP_C_CORE_PIPE_CTRL_PERF_EN enables the output-stall counter.  |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module sdp_c_core_pipe_ctrl #(
   parameter int DEPTH = 3,
   parameter int CNT_W = 16
) (
   input  logic             nvdla_core_clk,
   input  logic             nvdla_core_rstn,
   input  logic             cfg_op_en,
   input  logic             chn_in_pvld,
   output logic             chn_in_prdy,
   output logic             chn_out_pvld,
   input  logic             chn_out_prdy,
   output logic             core_wen,
   output logic [DEPTH-1:0] stage_vld,
   output logic [2:0]       fsm_output,
   output logic [CNT_W-1:0] beat_cnt,
   output logic             op_done,
   output logic [31:0]      perf_stall_cnt
);

   typedef enum logic [2:0] {
      IDLE  = 3'b001,
      RUN   = 3'b010,
      DRAIN = 3'b100
   } state_t;

   localparam logic [DEPTH-1:0] LAST_ONLY = {1'b1, {(DEPTH-1){1'b0}}};

   state_t state;
   state_t state_nxt;
   logic   adv;
   logic   in_acc;
   logic   out_acc;
   logic   op_start;
   logic   drain_done;

   // The whole core moves as one: any stall at the output freezes every stage.
   assign adv          = ~stage_vld[DEPTH-1] | chn_out_prdy;
   assign core_wen     = adv & ((state == RUN) | (state == DRAIN));
   assign chn_in_prdy  = (state == RUN) & adv;
   assign in_acc       = chn_in_pvld & chn_in_prdy;
   assign chn_out_pvld = stage_vld[DEPTH-1];
   assign out_acc      = chn_out_pvld & chn_out_prdy;
   assign fsm_output   = state;
   assign op_start     = (state == IDLE) & cfg_op_en;
   assign drain_done   = (stage_vld == '0) | ((stage_vld == LAST_ONLY) & out_acc);

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (cfg_op_en)  state_nxt = RUN;
         RUN:     if (!cfg_op_en) state_nxt = DRAIN;
         DRAIN:   if (drain_done) state_nxt = IDLE;
         default:                 state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         stage_vld <= '0;
      end else if (core_wen) begin
         stage_vld <= {stage_vld[DEPTH-2:0], in_acc};
      end
   end

   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         op_done <= 1'b0;
      end else begin
         op_done <= (state == DRAIN) & drain_done;
      end
   end

   // Count survives IDLE so software can read it after op_done.
   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         beat_cnt <= '0;
      end else if (op_start) begin
         beat_cnt <= '0;
      end else if (out_acc) begin
         beat_cnt <= beat_cnt + CNT_W'(1);
      end
   end

`ifdef SDP_C_CORE_PIPE_CTRL_PERF_EN
   logic        stall;
   logic [31:0] perf_cnt;

   assign stall = chn_out_pvld & ~chn_out_prdy;

   always_ff @(posedge nvdla_core_clk or negedge nvdla_core_rstn) begin
      if (!nvdla_core_rstn) begin
         perf_cnt <= 32'd0;
      end else if (op_start) begin
         perf_cnt <= 32'd0;
      end else if (stall && (perf_cnt != 32'hFFFF_FFFF)) begin
         perf_cnt <= perf_cnt + 32'd1;
      end
   end

   assign perf_stall_cnt = perf_cnt;
`else
   assign perf_stall_cnt = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_sdp_c_core_pipe_ctrl.sv
`default_nettype none
// Bench for sdp_c_core_pipe_ctrl: per-scenario tasks plus a beat scoreboard that
// follows an emulated core datapath clocked by core_wen.
module tb_sdp_c_core_pipe_ctrl;
   localparam int DEPTH = 3;
   localparam int CNT_W = 16;

   logic             clk = 1'b0;
   logic             rstn;
   logic             cfg_op_en;
   logic             chn_in_pvld;
   logic             chn_in_prdy;
   logic             chn_out_pvld;
   logic             chn_out_prdy;
   logic             core_wen;
   logic [DEPTH-1:0] stage_vld;
   logic [2:0]       fsm_output;
   logic [CNT_W-1:0] beat_cnt;
   logic             op_done;
   logic [31:0]      perf_stall_cnt;

   always #5 clk = ~clk;

   sdp_c_core_pipe_ctrl #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .nvdla_core_clk (clk),
      .nvdla_core_rstn(rstn),
      .cfg_op_en      (cfg_op_en),
      .chn_in_pvld    (chn_in_pvld),
      .chn_in_prdy    (chn_in_prdy),
      .chn_out_pvld   (chn_out_pvld),
      .chn_out_prdy   (chn_out_prdy),
      .core_wen       (core_wen),
      .stage_vld      (stage_vld),
      .fsm_output     (fsm_output),
      .beat_cnt       (beat_cnt),
      .op_done        (op_done),
      .perf_stall_cnt (perf_stall_cnt)
   );

   typedef struct {
      int     id;
      longint cyc;
   } exp_t;

   exp_t   sb[$];
   int     checks = 0;
   int     errors = 0;
   longint cyc = 0;
   int     in_id = 0;
   bit     lat_chk = 1'b0;
   int     pipe_id[DEPTH];

`ifdef SDP_C_CORE_PIPE_CTRL_PERF_EN
   localparam logic [31:0] EXP_STALL = 32'd5;
`else
   localparam logic [31:0] EXP_STALL = 32'd0;
`endif

   always @(posedge clk) cyc <= cyc + 1;

   // Emulated core: beat ids move through DEPTH registers whenever core_wen is high.
   initial begin : monitor
      exp_t e;
      bit   acc;
      for (int i = 0; i < DEPTH; i++) pipe_id[i] = -1;
      forever begin
         @(negedge clk);
         if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) pipe_id[i] = -1;
            sb.delete();
         end else begin
            acc = chn_in_pvld & chn_in_prdy;
            if (chn_out_pvld && chn_out_prdy) begin
               checks++;
               if (sb.size() == 0) begin
                  errors++;
                  $display("FAIL out_unexpected: beat id %0d delivered, no beat outstanding", pipe_id[DEPTH-1]);
               end else begin
                  e = sb.pop_front();
                  if (pipe_id[DEPTH-1] !== e.id) begin
                     errors++;
                     $display("FAIL out_order: got beat id %0d, required %0d", pipe_id[DEPTH-1], e.id);
                  end
                  if (e.cyc >= 0) begin
                     checks++;
                     if (cyc !== e.cyc) begin
                        errors++;
                        $display("FAIL out_latency: beat %0d out at cycle %0d, required %0d", e.id, cyc, e.cyc);
                     end
                  end
               end
            end
            if (acc) begin
               e.id  = in_id;
               e.cyc = lat_chk ? cyc + DEPTH : -1;
               sb.push_back(e);
            end
            if (core_wen) begin
               for (int i = DEPTH-1; i > 0; i--) pipe_id[i] = pipe_id[i-1];
               pipe_id[0] = acc ? in_id : -1;
            end
            if (acc) in_id++;
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive_beats(input int n, input bit every_other);
      int sent = 0;
      int guard = 0;
      bit acc;
      chn_in_pvld = 1'b1;
      while (sent < n && guard < 200) begin
         @(negedge clk);
         acc = chn_in_pvld & chn_in_prdy;
         if (acc) sent++;
         step();
         guard++;
         if (every_other && acc) chn_in_pvld = 1'b0;
         else                    chn_in_pvld = (sent < n);
      end
      chn_in_pvld = 1'b0;
      checks++;
      if (sent < n) begin
         errors++;
         $display("FAIL drive_timeout: accepted %0d beats, required %0d", sent, n);
      end
   endtask

   task automatic wait_empty(input string tag);
      bit ok = 1'b0;
      for (int g = 0; g < 50; g++) begin
         @(negedge clk);
         #1;
         if (sb.size() == 0 && stage_vld == '0) begin
            ok = 1'b1;
            break;
         end
      end
      checks++;
      if (!ok) begin
         errors++;
         $display("FAIL %s_drain_timeout: %0d beats outstanding, required 0", tag, sb.size());
      end
      step();
   endtask

   task automatic test_reset();
      rstn = 1'b0; cfg_op_en = 1'b0; chn_in_pvld = 1'b0; chn_out_prdy = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks += 8;
      if (fsm_output !== 3'b001) begin errors++; $display("FAIL rst_fsm: got %b, required 001", fsm_output); end
      if (stage_vld !== 3'b000) begin errors++; $display("FAIL rst_stage_vld: got %b, required 000", stage_vld); end
      if (chn_in_prdy !== 1'b0) begin errors++; $display("FAIL rst_in_prdy: got %b, required 0", chn_in_prdy); end
      if (chn_out_pvld !== 1'b0) begin errors++; $display("FAIL rst_out_pvld: got %b, required 0", chn_out_pvld); end
      if (core_wen !== 1'b0) begin errors++; $display("FAIL rst_core_wen: got %b, required 0", core_wen); end
      if (beat_cnt !== 16'd0) begin errors++; $display("FAIL rst_beat_cnt: got %0d, required 0", beat_cnt); end
      if (op_done !== 1'b0) begin errors++; $display("FAIL rst_op_done: got %b, required 0", op_done); end
      if (perf_stall_cnt !== 32'd0) begin errors++; $display("FAIL rst_perf: got %0d, required 0", perf_stall_cnt); end
      step();
      rstn = 1'b1;
      @(negedge clk);
      checks++;
      if (fsm_output !== 3'b001) begin errors++; $display("FAIL idle_hold_fsm: got %b, required 001", fsm_output); end
      step();
   endtask

   task automatic test_stream();
      lat_chk = 1'b1; chn_out_prdy = 1'b1; cfg_op_en = 1'b1;
      step();
      @(negedge clk);
      checks += 2;
      if (fsm_output !== 3'b010) begin errors++; $display("FAIL stream_fsm: got %b, required 010", fsm_output); end
      if (beat_cnt !== 16'd0) begin errors++; $display("FAIL stream_cnt_start: got %0d, required 0", beat_cnt); end
      step();
      drive_beats(8, 1'b0);
      wait_empty("stream");
      checks++;
      if (beat_cnt !== 16'd8) begin errors++; $display("FAIL stream_beat_cnt: got %0d, required 8", beat_cnt); end
   endtask

   task automatic test_backpressure();
      bit found = 1'b0;
      lat_chk = 1'b0; chn_out_prdy = 1'b0; chn_in_pvld = 1'b1;
      for (int g = 0; g < 10; g++) begin
         @(negedge clk);
         if (stage_vld === 3'b111) begin found = 1'b1; break; end
         step();
      end
      checks++;
      if (!found) begin errors++; $display("FAIL bp_fill: stage_vld %b, required 111", stage_vld); end
      for (int s = 0; s < 5; s++) begin
         if (s > 0) @(negedge clk);
         checks += 3;
         if (core_wen !== 1'b0) begin errors++; $display("FAIL bp_core_wen: got %b, required 0", core_wen); end
         if (chn_in_prdy !== 1'b0) begin errors++; $display("FAIL bp_in_prdy: got %b, required 0", chn_in_prdy); end
         if (stage_vld !== 3'b111) begin errors++; $display("FAIL bp_stage_hold: got %b, required 111", stage_vld); end
         step();
      end
      chn_out_prdy = 1'b1;
      @(negedge clk);
      checks++;
      if (perf_stall_cnt !== EXP_STALL) begin errors++; $display("FAIL bp_perf: got %0d, required %0d", perf_stall_cnt, EXP_STALL); end
      step();
      repeat (3) step();
      chn_in_pvld = 1'b0;
      wait_empty("bp");
      checks++;
      if (beat_cnt !== 16'd15) begin errors++; $display("FAIL bp_beat_cnt: got %0d, required 15", beat_cnt); end
   endtask

   task automatic test_drain();
      lat_chk = 1'b1; chn_in_pvld = 1'b1; cfg_op_en = 1'b0;
      @(negedge clk);
      checks += 2;
      if (fsm_output !== 3'b010) begin errors++; $display("FAIL drain_pre_fsm: got %b, required 010", fsm_output); end
      if (chn_in_prdy !== 1'b1) begin errors++; $display("FAIL drain_last_acc: got %b, required 1", chn_in_prdy); end
      step();
      chn_in_pvld = 1'b0;
      @(negedge clk);
      checks += 3;
      if (fsm_output !== 3'b100) begin errors++; $display("FAIL drain_fsm: got %b, required 100", fsm_output); end
      if (chn_in_prdy !== 1'b0) begin errors++; $display("FAIL drain_in_prdy: got %b, required 0", chn_in_prdy); end
      if (stage_vld !== 3'b001) begin errors++; $display("FAIL drain_stage: got %b, required 001", stage_vld); end
      step();
      step();
      @(negedge clk);
      checks += 3;
      if (fsm_output !== 3'b100) begin errors++; $display("FAIL drain_last_fsm: got %b, required 100", fsm_output); end
      if (chn_out_pvld !== 1'b1) begin errors++; $display("FAIL drain_out_pvld: got %b, required 1", chn_out_pvld); end
      if (op_done !== 1'b0) begin errors++; $display("FAIL drain_early_done: got %b, required 0", op_done); end
      step();
      @(negedge clk);
      checks += 2;
      if (fsm_output !== 3'b001) begin errors++; $display("FAIL drain_idle_fsm: got %b, required 001", fsm_output); end
      if (op_done !== 1'b1) begin errors++; $display("FAIL drain_op_done: got %b, required 1", op_done); end
      step();
      @(negedge clk);
      checks += 3;
      if (op_done !== 1'b0) begin errors++; $display("FAIL drain_done_pulse: got %b, required 0", op_done); end
      if (fsm_output !== 3'b001) begin errors++; $display("FAIL drain_stay_idle: got %b, required 001", fsm_output); end
      if (beat_cnt !== 16'd16) begin errors++; $display("FAIL drain_beat_cnt: got %0d, required 16", beat_cnt); end
      step();
   endtask

   task automatic test_reenable_drain();
      lat_chk = 1'b1; cfg_op_en = 1'b1;
      step();
      chn_in_pvld = 1'b1;
      @(negedge clk);
      checks += 2;
      if (fsm_output !== 3'b010) begin errors++; $display("FAIL re_run_fsm: got %b, required 010", fsm_output); end
      if (chn_in_prdy !== 1'b1) begin errors++; $display("FAIL re_acc0: got %b, required 1", chn_in_prdy); end
      step();
      cfg_op_en = 1'b0;
      @(negedge clk);
      checks++;
      if (chn_in_prdy !== 1'b1) begin errors++; $display("FAIL re_acc1: got %b, required 1", chn_in_prdy); end
      step();
      chn_in_pvld = 1'b0; cfg_op_en = 1'b1;
      @(negedge clk);
      checks += 2;
      if (fsm_output !== 3'b100) begin errors++; $display("FAIL re_drain0: got %b, required 100", fsm_output); end
      if (stage_vld !== 3'b011) begin errors++; $display("FAIL re_stage0: got %b, required 011", stage_vld); end
      step();
      @(negedge clk);
      checks++;
      if (fsm_output !== 3'b100) begin errors++; $display("FAIL re_drain1: got %b, required 100", fsm_output); end
      step();
      @(negedge clk);
      checks += 2;
      if (fsm_output !== 3'b100) begin errors++; $display("FAIL re_drain2: got %b, required 100", fsm_output); end
      if (stage_vld !== 3'b100) begin errors++; $display("FAIL re_stage2: got %b, required 100", stage_vld); end
      step();
      @(negedge clk);
      checks += 3;
      if (fsm_output !== 3'b001) begin errors++; $display("FAIL re_idle: got %b, required 001", fsm_output); end
      if (op_done !== 1'b1) begin errors++; $display("FAIL re_op_done: got %b, required 1", op_done); end
      if (beat_cnt !== 16'd2) begin errors++; $display("FAIL re_cnt_hold: got %0d, required 2", beat_cnt); end
      step();
      @(negedge clk);
      checks += 2;
      if (fsm_output !== 3'b010) begin errors++; $display("FAIL re_restart: got %b, required 010", fsm_output); end
      if (beat_cnt !== 16'd0) begin errors++; $display("FAIL re_cnt_clear: got %0d, required 0", beat_cnt); end
      step();
      cfg_op_en = 1'b0;
      wait_empty("re");
      repeat (3) step();
   endtask

   task automatic test_bubbles();
      cfg_op_en = 1'b1;
      step();
      lat_chk = 1'b1;
      for (int i = 0; i < 8; i++) begin
         logic [DEPTH-1:0] exp_sv;
         chn_in_pvld = (i % 2 == 0);
         exp_sv = (i % 2 == 0) ? 3'b010 : 3'b101;
         @(negedge clk);
         if (i >= 2) begin
            checks++;
            if (stage_vld !== exp_sv) begin errors++; $display("FAIL bub_stage_%0d: got %b, required %b", i, stage_vld, exp_sv); end
         end
         step();
      end
      chn_in_pvld = 1'b0; cfg_op_en = 1'b0;
      wait_empty("bub");
      checks++;
      if (beat_cnt !== 16'd4) begin errors++; $display("FAIL bub_beat_cnt: got %0d, required 4", beat_cnt); end
      repeat (3) step();
   endtask

   task automatic test_reset_midop();
      bit found = 1'b0;
      cfg_op_en = 1'b1; chn_out_prdy = 1'b1; lat_chk = 1'b1;
      step();
      drive_beats(2, 1'b0);
      wait_empty("mid");
      lat_chk = 1'b0; chn_out_prdy = 1'b0; chn_in_pvld = 1'b1;
      for (int g = 0; g < 10; g++) begin
         @(negedge clk);
         if (stage_vld === 3'b111) begin found = 1'b1; break; end
         step();
      end
      checks += 2;
      if (!found) begin errors++; $display("FAIL mid_fill: stage_vld %b, required 111", stage_vld); end
      if (beat_cnt !== 16'd2) begin errors++; $display("FAIL mid_pre_cnt: got %0d, required 2", beat_cnt); end
      step();
      rstn = 1'b0;
      #1;
      checks += 5;
      if (fsm_output !== 3'b001) begin errors++; $display("FAIL mid_fsm: got %b, required 001", fsm_output); end
      if (stage_vld !== 3'b000) begin errors++; $display("FAIL mid_stage: got %b, required 000", stage_vld); end
      if (chn_in_prdy !== 1'b0) begin errors++; $display("FAIL mid_in_prdy: got %b, required 0", chn_in_prdy); end
      if (beat_cnt !== 16'd0) begin errors++; $display("FAIL mid_beat_cnt: got %0d, required 0", beat_cnt); end
      if (core_wen !== 1'b0) begin errors++; $display("FAIL mid_core_wen: got %b, required 0", core_wen); end
      chn_in_pvld = 1'b0; cfg_op_en = 1'b0; chn_out_prdy = 1'b1;
      step();
      rstn = 1'b1;
      step();
      @(negedge clk);
      checks += 2;
      if (fsm_output !== 3'b001) begin errors++; $display("FAIL mid_post_fsm: got %b, required 001", fsm_output); end
      if (perf_stall_cnt !== 32'd0) begin errors++; $display("FAIL mid_perf: got %0d, required 0", perf_stall_cnt); end
   endtask

   initial begin
      test_reset();
      test_stream();
      test_backpressure();
      test_drain();
      test_reenable_drain();
      test_bubbles();
      test_reset_midop();
      checks++;
      if (sb.size() != 0) begin errors++; $display("FAIL sb_leftover: %0d beats outstanding, required 0", sb.size()); end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish, required finish before 1ms");
      $fatal(1, "watchdog expired");
   end
endmodule
`default_nettype wire
